// File: rtl/mt_thread_sched_pkg.sv
// Shared barrel-fetch constants used by mt_pc and mt_thread_sched.
//   NUM_THREADS  : hardware thread count
//   BITS_THREADS : thread-id width
//   PIPE_DEPTH   : fetch pipeline depth, default minimum re-issue gap
package mt_thread_sched_pkg;

  localparam int unsigned NUM_THREADS  = 8;
  localparam int unsigned BITS_THREADS = $clog2(NUM_THREADS);
  localparam int unsigned PIPE_DEPTH   = 5;

  // Cooldown counter width able to hold gap-1 with headroom
  function automatic int unsigned cool_bits(input int unsigned gap);
    return $clog2(gap) + 1;
  endfunction

endpackage

// File: rtl/mt_thread_sched_rr_pick.sv
// Round-robin picker: first set bit of i_elig at or after i_start, wrapping.
//   i_elig  : eligible-thread vector
//   i_start : index where the scan begins
//   o_found : at least one eligible thread
//   o_idx   : chosen thread index (valid when o_found)
module rr_pick #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] i_elig,
  input  logic [W-1:0] i_start,
  output logic         o_found,
  output logic [W-1:0] o_idx
);

  localparam int unsigned WE = W + 1;

  logic [N-1:0] w_rot;
  logic [W-1:0] w_off;

  // (a + b) mod N for a, b < N
  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [WE-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= WE'(N)) s = s - WE'(N);
    return W'(s);
  endfunction

  // Rotate so bit 0 is the scan start
  always_comb begin
    w_rot = '0;
    for (int k = 0; k < N; k++) begin
      w_rot[k] = i_elig[wrap_add(i_start, W'(k))];
    end
  end

  // Lowest-index priority encode of the rotated vector
  always_comb begin
    o_found = 1'b0;
    w_off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_found = 1'b1;
        w_off   = W'(k);
      end
    end
  end

  assign o_idx = wrap_add(i_start, w_off);

endmodule

// File: rtl/mt_thread_sched.sv
// Barrel thread scheduler: round-robin over active threads with per-thread
// cooldown so no thread re-issues within MIN_GAP non-stall cycles.
//   clk, rst          : clock, async active-low reset
//   stall_f           : freezes selection and cooldowns
//   start_valid/_tid  : activate a thread
//   halt_valid/_tid   : deactivate a thread (wins over same-tid start)
//   tid, tid_valid    : registered issue slot (tid_valid=0 is a bubble)
//   active_mask       : registered active bits
//   idle              : no active thread
module mt_thread_sched #(
  parameter int unsigned NUM_THREADS  = mt_thread_sched_pkg::NUM_THREADS,
  parameter int unsigned BITS_THREADS = $clog2(NUM_THREADS),
  parameter int unsigned MIN_GAP      = mt_thread_sched_pkg::PIPE_DEPTH,
  parameter logic [NUM_THREADS-1:0] BOOT_MASK = {{(NUM_THREADS-1){1'b0}}, 1'b1}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_f,
  input  logic                    start_valid,
  input  logic [BITS_THREADS-1:0] start_tid,
  input  logic                    halt_valid,
  input  logic [BITS_THREADS-1:0] halt_tid,
  output logic [BITS_THREADS-1:0] tid,
  output logic                    tid_valid,
  output logic [NUM_THREADS-1:0]  active_mask,
  output logic                    idle
);

  import mt_thread_sched_pkg::*;

  localparam int unsigned COOL_W = cool_bits(MIN_GAP);
  localparam logic [COOL_W-1:0]       COOL_RELOAD  = COOL_W'(MIN_GAP - 1);
  localparam logic [BITS_THREADS-1:0] LAST_TID_RST = BITS_THREADS'(NUM_THREADS - 1);

  logic [BITS_THREADS-1:0] r_last_tid;
  logic [COOL_W-1:0]       r_cool [NUM_THREADS];

  logic [NUM_THREADS-1:0]  w_elig;
  logic [NUM_THREADS-1:0]  w_active_next;
  logic [BITS_THREADS-1:0] w_start_idx;
  logic                    w_found;
  logic [BITS_THREADS-1:0] w_pick;

  // Eligibility uses pre-edge state only
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      w_elig[i] = active_mask[i] && (r_cool[i] == '0);
    end
  end

  // Start then halt, so halt wins on a same-tid collision
  always_comb begin
    w_active_next = active_mask;
    if (start_valid) w_active_next[start_tid] = 1'b1;
    if (halt_valid)  w_active_next[halt_tid]  = 1'b0;
  end

  assign w_start_idx = (r_last_tid == LAST_TID_RST) ? '0 : r_last_tid + 1'b1;

  rr_pick #(
    .N (NUM_THREADS),
    .W (BITS_THREADS)
  ) u_rr_pick (
    .i_elig  (w_elig),
    .i_start (w_start_idx),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  // Issue, cooldown and active-mask state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tid         <= '0;
      tid_valid   <= 1'b0;
      r_last_tid  <= LAST_TID_RST;
      active_mask <= BOOT_MASK;
      for (int j = 0; j < NUM_THREADS; j++) r_cool[j] <= '0;
    end else begin
      active_mask <= w_active_next;
      if (!stall_f) begin
        tid_valid <= w_found;
        if (w_found) begin
          tid        <= w_pick;
          r_last_tid <= w_pick;
        end
        for (int j = 0; j < NUM_THREADS; j++) begin
          if (w_found && (w_pick == BITS_THREADS'(j))) r_cool[j] <= COOL_RELOAD;
          else if (r_cool[j] != '0)                      r_cool[j] <= r_cool[j] - 1'b1;
        end
      end
    end
  end

  assign idle = (active_mask == '0);

endmodule

// File: doc/mt_thread_sched.md
# mt_thread_sched

Upstream neighbour of `mt_pc` in the barrel fetch stage: each cycle it chooses the hardware thread whose PC is fetched, driving `mt_pc.tid`. It keeps a per-thread active mask, changed by start and halt events from later stages. Selection is round-robin over active threads, with a per-thread cooldown so one thread is never issued twice within the pipeline depth. Inactive or cooling threads are skipped, and a bubble (`tid_valid`=0) is issued when no thread is eligible.

## Interface
- `NUM_THREADS`, 8: number of hardware threads.
- `BITS_THREADS`, `$clog2(NUM_THREADS)`: thread-id width.
- `MIN_GAP`, 5: minimum cycles between two issues of the same thread; legal range 1..NUM_THREADS.
- `BOOT_MASK`, `{{(NUM_THREADS-1){1'b0}},1'b1}`: active mask loaded at reset.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `stall_f`  in  1  fetch stall; freezes selection and cooldowns.
- `start_valid`  in  1  activate thread `start_tid`.
- `start_tid`  in  BITS_THREADS  thread to activate.
- `halt_valid`  in  1  deactivate thread `halt_tid`.
- `halt_tid`  in  BITS_THREADS  thread to deactivate.
- `tid`  out  BITS_THREADS  selected thread, registered; feeds `mt_pc.tid`.
- `tid_valid`  out  1  `tid` is a real issue; 0 marks a bubble.
- `active_mask`  out  NUM_THREADS  current active bits, registered.
- `idle`  out  1  `active_mask==0`; combinational from register.

## Operation
- State:
  - `active[NUM_THREADS]`.
  - `cool[NUM_THREADS]`, each `$clog2(MIN_GAP)+1` bits.
  - `last_tid`.
  - Output registers `tid` and `tid_valid`.
- Eligibility: thread i is eligible when `active[i] && cool[i]==0`. Both values are taken from current register state, before this edge's start/halt updates.
- Pick (edge, `stall_f`=0):
  - Scan from `last_tid+1` upward, wrapping modulo NUM_THREADS, and take the first eligible thread p.
  - If p exists: `tid<=p`, `tid_valid<=1`, `last_tid<=p`, `cool[p]<=MIN_GAP-1`.
  - If none: `tid_valid<=0`; `tid` and `last_tid` hold.
- Cooldown: on each non-stall edge, every `cool[j]!=0` not being reloaded decrements by 1, saturating at 0.
- Stall (edge, `stall_f`=1): `tid`, `tid_valid`, `last_tid` and `cool` all hold.
- Start/halt: these update `active` on every edge, regardless of `stall_f`.
  - start sets the bit; halt clears it.
  - If both name the same tid on the same edge, halt wins.
  - Start of an already-active thread, or halt of an inactive thread, is a no-op.
  - Neither event alters `cool`.
- A halted thread already issued, with `tid_valid` high this cycle, is not recalled; squashing is downstream's responsibility.
- Steady state with all threads active and MIN_GAP≤NUM_THREADS is strict rotation: 0,1,…,NUM_THREADS-1,0,…

## Timing
- Reset values:
  - `tid`=0, `tid_valid`=0.
  - `last_tid`=NUM_THREADS-1, so the first pick starts scanning at thread 0.
  - All `cool`=0.
  - `active_mask`=BOOT_MASK.
- Latency:
  - The first issue appears one edge after `rst` deasserts.
  - A start seen at edge k makes the thread eligible at edge k+1, so its first issue is visible after edge k+1.
  - A halt at edge k prevents selection from edge k+1 onward.
- The same thread's issue edges are spaced by ≥MIN_GAP non-stall edges.
- Reset asserted mid-operation immediately forces all registers to their reset values, including during a stall.

## Structure
- Shared barrel package/header holds NUM_THREADS, BITS_THREADS, and PIPE_DEPTH, which is the default source for MIN_GAP. `mt_pc` and this block use the same constants.
- One combinational sub-module, `rr_pick`:
  - Inputs: eligible vector and start index (`last_tid+1`).
  - Outputs: found flag and index.
  - Implemented as rotate, priority-encode, then add-back modulo NUM_THREADS.
- The sequential logic stays in `mt_thread_sched`.

## Test plan
- Reset with BOOT_MASK=1, MIN_GAP=5, no events: `tid_valid` pattern 1,0,0,0,0,1,… with `tid`=0 on every valid cycle.
- Start threads 1..7, one per cycle, after reset: strict rotation converges to `tid` 0,1,…,7,0 with `tid_valid` constantly 1.
- All threads active, halt thread 3: the next rotation goes 2→4; `active_mask`=8'hF7, with no bubble.
- Hold `stall_f` for 3 cycles mid-rotation at `tid`=5: `tid`=5 held for 3 cycles, then 6 follows, and the cooldown gap is preserved.
- Same-edge start_tid=2 and halt_tid=2 with thread 2 inactive: `active_mask[2]` stays 0; halting the last active thread sets `idle`=1 and `tid_valid`=0.
- Assert `rst` low asynchronously between edges while `tid`=6: outputs go immediately to `tid`=0, `tid_valid`=0, `active_mask`=BOOT_MASK.
